aes_gcm_ghash_stage: RTL and testbench
======================================

AES_GCM_GHASH_STAGE -- requirements
Module: aes_gcm_ghash_stage

Interface
REQ-001 The block SHALL have one clock `clk` and an asynchronous active-low reset `rst_n`, which is decided and fixed.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 i_valid  in  1  upstream block valid; upstream SHALL hold all inputs stable while i_valid=1 and o_ready=0.
REQ-005 i_phase  in  3  block type: 3'd1 AAD, 3'd2 PT, 3'd3 LEN (final); other codes are bubbles.
REQ-006 i_h, i_encrypted_j0, i_encrypted_cb, i_plain_text, i_aad, i_instance_size  in  128 each  final-round AES results and carried operands; bit 0 is the MSB; i_instance_size is len(A)||len(C) in bits.
REQ-007 o_ready  out  1  block accepted on a cycle with i_valid=1 and o_ready=1.
REQ-008 o_ct  out  128  ciphertext block; o_ct_valid  out  1  one-cycle strobe.
REQ-009 o_tag  out  128  authentication tag; o_tag_valid  out  1  one-cycle strobe.

Function
REQ-010 States SHALL be IDLE, MUL and TAG; o_ready SHALL be 1 only in IDLE.
REQ-011 An accepted bubble SHALL be dropped with no state change.
REQ-012 The first non-bubble block of an instance SHALL latch i_h into H and i_encrypted_j0 into EJ0; later blocks of the same instance SHALL NOT reload them.
REQ-013 Operand X: AAD gives Y^i_aad; PT gives Y^C with C=i_plain_text^i_encrypted_cb; LEN gives Y^i_instance_size; Y is the 128-bit GHASH accumulator.
REQ-014 On PT acceptance, o_ct SHALL equal C and o_ct_valid SHALL pulse on the next cycle; o_ct SHALL hold its value until the next PT block.
REQ-015 On acceptance the block SHALL enter MUL and compute Y = X*H in GF(2^128) bit-serially, 1 bit per cycle, processing X bit 0 first.
REQ-016 Per MUL cycle: if X[i]=1 then Z^=V; V = V>>1, then V ^= 0xE1||0^120 when the shifted-out bit V[127] was 1; Z starts at 0 and V starts at H.
REQ-017 MUL SHALL last exactly 128 cycles, then update Y.
REQ-018 After MUL, AAD and PT blocks SHALL return to IDLE, and the first new acceptance SHALL be possible on the following cycle.
REQ-019 After MUL, a LEN block SHALL enter TAG for one cycle: o_tag = Y^EJ0, o_tag_valid=1, then Y, H and EJ0 SHALL be cleared and the block SHALL return to IDLE.
REQ-020 A LEN block as the first block of an instance (empty AAD and PT) SHALL be legal and SHALL latch H and EJ0 per REQ-012.
REQ-021 Inputs SHALL be ignored outside IDLE; any acceptance-cycle effects SHALL occur in the same cycle as the MUL start.

Reset
REQ-022 Asserting rst_n low SHALL immediately set state=IDLE, Y=H=EJ0=Z=V=0, o_ct=0, o_tag=0, o_ct_valid=0, o_tag_valid=0 and o_ready=0.
REQ-023 o_ready SHALL rise on the first clock edge after reset deassertion.
REQ-024 Reset during MUL or TAG SHALL abort the instance with no strobe issued.

Configuration
REQ-025 Macro GHASH_DIGIT4_EN: when defined, MUL SHALL process 4 X-bits per cycle, applying REQ-016 four times combinationally, and SHALL last 32 cycles.
REQ-026 Without GHASH_DIGIT4_EN, MUL SHALL last 128 cycles; results SHALL be bit-identical in both builds.

Verification
REQ-027 Empty instance: LEN block with i_h=66e94bd4ef8a2c3b884cfa59ca342b2e, i_encrypted_j0=58e2fccefa7e3061367f1d57a4e7455a, i_instance_size=0 -> o_tag=58e2fccefa7e3061367f1d57a4e7455a, strobe 129 cycles after acceptance (33 with macro).
REQ-028 PT block with pt=0, i_encrypted_cb=0388dace60b6a392f328c2b971b2fe78 and the same H, then LEN block with size=0x...0080 -> o_ct=0388dace60b6a392f328c2b971b2fe78, o_tag=ab6e47d42cec13bdf53a67b21257bddf.
REQ-029 Bubbles (phase 0, 4 and 7) interleaved in REQ-028 -> identical o_ct and o_tag with no extra strobes.
REQ-030 i_valid held high during MUL with changing data -> only the IDLE-cycle data is consumed; o_ready stays 0 for exactly 128 cycles (32 with macro).
REQ-031 rst_n pulsed at MUL cycle 60, then REQ-027 rerun -> no strobe before the rerun, and the correct tag after it.

Source files
------------

// File: rtl/aes_gcm_ghash_stage.sv
// GCM GHASH/tag stage: bit-serial GF(2^128) multiply of the running hash by H, ciphertext XOR and final tag.
// Optional build macro GHASH_DIGIT4_EN retires four multiplier bits per cycle (32-cycle multiply).
module aes_gcm_ghash_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [2:0]   i_phase,
    input  logic [127:0] i_h,
    input  logic [127:0] i_encrypted_j0,
    input  logic [127:0] i_encrypted_cb,
    input  logic [127:0] i_plain_text,
    input  logic [127:0] i_aad,
    input  logic [127:0] i_instance_size,
    output logic         o_ready,
    output logic [127:0] o_ct,
    output logic         o_ct_valid,
    output logic [127:0] o_tag,
    output logic         o_tag_valid
);

`ifdef GHASH_DIGIT4_EN
    localparam int DIGIT = 4;
`else
    localparam int DIGIT = 1;
`endif
    localparam int           MUL_CYCLES = 128 / DIGIT;
    localparam logic [6:0]   CNT_LAST   = 7'(MUL_CYCLES - 1);
    localparam logic [127:0] R_POLY     = {8'hE1, 120'd0};
    localparam logic [2:0]   PH_AAD     = 3'd1;
    localparam logic [2:0]   PH_PT      = 3'd2;
    localparam logic [2:0]   PH_LEN     = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         ready_q, ready_d;
    logic [127:0] y_q, y_d;
    logic [127:0] h_q, h_d;
    logic [127:0] ej0_q, ej0_d;
    logic [127:0] z_q, z_d;
    logic [127:0] v_q, v_d;
    logic [127:0] x_q, x_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         len_q, len_d;
    logic         active_q, active_d;
    logic [127:0] ct_q, ct_d;
    logic         ct_vld_q, ct_vld_d;
    logic [127:0] tag_q, tag_d;
    logic         tag_vld_q, tag_vld_d;

    logic         accept;
    logic         is_block;
    logic         start;
    logic         mul_last;
    logic [127:0] ct_blk;
    logic [127:0] blk;
    logic [127:0] h_eff;
    logic [127:0] ej0_eff;
    logic [127:0] z_step;
    logic [127:0] v_step;

    // V >> 1 in GCM bit order, folding the dropped x^127 term back via the field polynomial.
    function automatic logic [127:0] gf_shift(input logic [127:0] v);
        return (v >> 1) ^ (v[0] ? R_POLY : 128'd0);
    endfunction

    assign accept   = (state_q == IDLE) && ready_q && i_valid;
    assign is_block = (i_phase == PH_AAD) || (i_phase == PH_PT) || (i_phase == PH_LEN);
    assign start    = accept && is_block;
    assign mul_last = (cnt_q == CNT_LAST);
    assign ct_blk   = i_plain_text ^ i_encrypted_cb;
    assign h_eff    = active_q ? h_q : i_h;
    assign ej0_eff  = active_q ? ej0_q : i_encrypted_j0;

    always_comb begin
        case (i_phase)
            PH_AAD:  blk = i_aad;
            PH_PT:   blk = ct_blk;
            PH_LEN:  blk = i_instance_size;
            default: blk = 128'd0;
        endcase
    end

    // One multiplier digit: X bits are consumed from the MSB (GCM bit 0) downwards.
    always_comb begin
        z_step = z_q;
        v_step = v_q;
        for (int k = 0; k < DIGIT; k++) begin
            if (x_q[127-k]) begin
                z_step = z_step ^ v_step;
            end
            v_step = gf_shift(v_step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_d = len_q ? TAG : IDLE;
                end
            end
            TAG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d   = (state_d == IDLE);
        y_d       = y_q;
        h_d       = h_q;
        ej0_d     = ej0_q;
        z_d       = z_q;
        v_d       = v_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        active_d  = active_q;
        ct_d      = ct_q;
        ct_vld_d  = 1'b0;
        tag_d     = tag_q;
        tag_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d      = h_eff;
                    ej0_d    = ej0_eff;
                    active_d = 1'b1;
                    x_d      = y_q ^ blk;
                    z_d      = 128'd0;
                    v_d      = h_eff;
                    cnt_d    = 7'd0;
                    len_d    = (i_phase == PH_LEN);
                    if (i_phase == PH_PT) begin
                        ct_d     = ct_blk;
                        ct_vld_d = 1'b1;
                    end
                end
            end
            MUL: begin
                z_d   = z_step;
                v_d   = v_step;
                x_d   = x_q << DIGIT;
                cnt_d = cnt_q + 7'd1;
                if (mul_last) begin
                    y_d = z_step;
                end
            end
            TAG: begin
                tag_d     = y_q ^ ej0_q;
                tag_vld_d = 1'b1;
                y_d       = 128'd0;
                h_d       = 128'd0;
                ej0_d     = 128'd0;
                active_d  = 1'b0;
                len_d     = 1'b0;
            end
            default: begin
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            y_q       <= 128'd0;
            h_q       <= 128'd0;
            ej0_q     <= 128'd0;
            z_q       <= 128'd0;
            v_q       <= 128'd0;
            x_q       <= 128'd0;
            cnt_q     <= 7'd0;
            len_q     <= 1'b0;
            active_q  <= 1'b0;
            ct_q      <= 128'd0;
            ct_vld_q  <= 1'b0;
            tag_q     <= 128'd0;
            tag_vld_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            y_q       <= y_d;
            h_q       <= h_d;
            ej0_q     <= ej0_d;
            z_q       <= z_d;
            v_q       <= v_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            active_q  <= active_d;
            ct_q      <= ct_d;
            ct_vld_q  <= ct_vld_d;
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_ct        = ct_q;
    assign o_ct_valid  = ct_vld_q;
    assign o_tag       = tag_q;
    assign o_tag_valid = tag_vld_q;

endmodule

// File: tb/tb_aes_gcm_ghash_stage.sv
// Self-checking bench for aes_gcm_ghash_stage: known GCM vectors, bubble/hold/reset sequences, random instances.
`timescale 1ns/1ps
module tb_aes_gcm_ghash_stage;

`ifdef GHASH_DIGIT4_EN
    localparam int MUL_CYC = 32;
`else
    localparam int MUL_CYC = 128;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [2:0]   i_phase = 3'd0;
    logic [127:0] i_h = '0, i_encrypted_j0 = '0, i_encrypted_cb = '0;
    logic [127:0] i_plain_text = '0, i_aad = '0, i_instance_size = '0;
    logic         o_ready, o_ct_valid, o_tag_valid;
    logic [127:0] o_ct, o_tag;

    aes_gcm_ghash_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_phase         (i_phase),
        .i_h             (i_h),
        .i_encrypted_j0  (i_encrypted_j0),
        .i_encrypted_cb  (i_encrypted_cb),
        .i_plain_text    (i_plain_text),
        .i_aad           (i_aad),
        .i_instance_size (i_instance_size),
        .o_ready         (o_ready),
        .o_ct            (o_ct),
        .o_ct_valid      (o_ct_valid),
        .o_tag           (o_tag),
        .o_tag_valid     (o_tag_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] ct_fifo[$];
    logic [127:0] tag_fifo[$];
    int           tag_cyc_fifo[$];
    always @(negedge clk) begin
        if (o_ct_valid) ct_fifo.push_back(o_ct);
        if (o_tag_valid) begin
            tag_fifo.push_back(o_tag);
            tag_cyc_fifo.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference multiply: carry-less polynomial product then reduction by x^128+x^7+x^2+x+1.
    function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] c;
        logic [127:0] r;
        c = '0;
        for (int i = 0; i < 128; i++)
            if (a[127-i])
                for (int j = 0; j < 128; j++)
                    if (b[127-j]) c[i+j] = ~c[i+j];
        for (int k = 254; k >= 128; k--) begin
            if (c[k]) begin
                c[k]     = 1'b0;
                c[k-121] = ~c[k-121];
                c[k-126] = ~c[k-126];
                c[k-127] = ~c[k-127];
                c[k-128] = ~c[k-128];
            end
        end
        for (int i = 0; i < 128; i++) r[127-i] = c[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [2:0] ph, input logic [127:0] h, input logic [127:0] ej0,
                        input logic [127:0] cb, input logic [127:0] pt, input logic [127:0] aad,
                        input logic [127:0] sz);
        bit ok;
        @(negedge clk);
        i_phase = ph; i_h = h; i_encrypted_j0 = ej0; i_encrypted_cb = cb;
        i_plain_text = pt; i_aad = aad; i_instance_size = sz;
        i_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (o_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        i_valid = 1'b0;
        acc_cyc = cyc;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: o_ready never 1 within 400 cycles, expected acceptance");
        end
    endtask

    task automatic wait_ct(output logic [127:0] v);
        int n = 0;
        while (ct_fifo.size() == 0 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (ct_fifo.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ct_timeout: no o_ct_valid strobe in 400 cycles, expected one");
            v = 'x;
        end else v = ct_fifo.pop_front();
    endtask

    task automatic wait_tag(output logic [127:0] v, output int lat);
        int n = 0;
        while (tag_fifo.size() == 0 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (tag_fifo.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tag_timeout: no o_tag_valid strobe in 400 cycles, expected one");
            v = 'x;
            lat = -1;
        end else begin
            v   = tag_fifo.pop_front();
            lat = tag_cyc_fifo.pop_front() - acc_cyc;
        end
    endtask

    typedef struct {
        logic         has_pt;
        logic [127:0] h, ej0, cb, pt, sz;
        logic [127:0] exp_ct, exp_tag;
    } vec_t;

    localparam logic [127:0] H_TC   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EJ0_TC = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] CB_TC  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG2   = 128'hab6e47d42cec13bdf53a67b21257bddf;

    initial begin
        vec_t         vt[3];
        logic [127:0] got, exp_y, c, sz, h, ej0, cb, pt, blk;
        int           lat, nA, nP, cnt, before_ct, before_tag;
        logic [2:0]   bph;

        vt[0] = '{1'b0, H_TC, EJ0_TC, '0, '0, 128'd0, '0, EJ0_TC};
        vt[1] = '{1'b1, H_TC, EJ0_TC, CB_TC, '0, 128'd128, CB_TC, TAG2};
        vt[2] = '{1'b1, 128'd0, 128'h000102030405060708090a0b0c0d0e0f,
                  128'hffff0000ffff0000ffff0000ffff0000, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
                  128'd128, 128'hf0f00f0ff0f00f0ff0f00f0ff0f00f0f,
                  128'h000102030405060708090a0b0c0d0e0f};

        // Reset values while rst_n is low, then o_ready rising on the first edge after release.
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {127'd0, o_ready}, 128'd0);
        check("rst_ct", o_ct, 128'd0);
        check("rst_tag", o_tag, 128'd0);
        check("rst_strobes", {126'd0, o_ct_valid, o_tag_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {127'd0, o_ready}, 128'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {127'd0, o_ready}, 128'd1);

        for (int t = 0; t < 3; t++) begin
            if (vt[t].has_pt) begin
                send(3'd2, vt[t].h, vt[t].ej0, vt[t].cb, vt[t].pt, rnd128(), rnd128());
                wait_ct(got);
                check($sformatf("vec%0d_ct", t), got, vt[t].exp_ct);
            end
            send(3'd3, vt[t].has_pt ? rnd128() : vt[t].h, vt[t].has_pt ? rnd128() : vt[t].ej0,
                 rnd128(), rnd128(), rnd128(), vt[t].sz);
            wait_tag(got, lat);
            check($sformatf("vec%0d_tag", t), got, vt[t].exp_tag);
            check_int($sformatf("vec%0d_tag_latency", t), lat, MUL_CYC + 1);
            if (vt[t].has_pt) check($sformatf("vec%0d_ct_hold", t), o_ct, vt[t].exp_ct);
        end

        // Bubbles interleaved around a PT/LEN instance.
        before_ct = ct_fifo.size();
        send(3'd0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
        check("bubble_keeps_ready", {127'd0, o_ready}, 128'd1);
        send(3'd2, H_TC, EJ0_TC, CB_TC, 128'd0, rnd128(), rnd128());
        send(3'd4, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
        send(3'd7, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
        check("bubble7_keeps_ready", {127'd0, o_ready}, 128'd1);
        send(3'd3, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 128'd128);
        wait_tag(got, lat);
        check("bubble_tag", got, TAG2);
        wait_ct(got);
        check("bubble_ct", got, CB_TC);
        repeat (5) @(negedge clk);
        #1;
        check_int("bubble_extra_ct", ct_fifo.size(), before_ct);
        check_int("bubble_extra_tag", tag_fifo.size(), 0);

        // i_valid held high with changing data throughout MUL.
        send(3'd2, H_TC, EJ0_TC, CB_TC, 128'd0, rnd128(), rnd128());
        i_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (o_ready) break;
            cnt++;
            i_phase = 3'd2; i_h = rnd128(); i_encrypted_j0 = rnd128(); i_encrypted_cb = rnd128();
            i_plain_text = rnd128(); i_aad = rnd128(); i_instance_size = rnd128();
        end
        i_valid = 1'b0;
        check_int("hold_ready_low_cycles", cnt, MUL_CYC);
        wait_ct(got);
        check("hold_ct", got, CB_TC);
        send(3'd3, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 128'd128);
        wait_tag(got, lat);
        check("hold_tag", got, TAG2);
        check_int("hold_extra_ct", ct_fifo.size(), 0);

        // Reset in the middle of MUL aborts silently; rerun gives the right tag.
        send(3'd3, H_TC, EJ0_TC, rnd128(), rnd128(), rnd128(), 128'd0);
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {127'd0, o_ready}, 128'd0);
        check("midrst_ct", o_ct, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        check_int("midrst_no_tag", tag_fifo.size(), 0);
        send(3'd3, H_TC, EJ0_TC, rnd128(), rnd128(), rnd128(), 128'd0);
        wait_tag(got, lat);
        check("midrst_rerun_tag", got, EJ0_TC);

        // Random instances against the reference model; non-first blocks carry junk H/EJ0.
        for (int t = 0; t < 10; t++) begin
            h = rnd128(); ej0 = rnd128(); exp_y = '0;
            nA = $urandom_range(0, 2); nP = $urandom_range(0, 2);
            before_tag = 0;
            for (int a = 0; a < nA; a++) begin
                if ($urandom_range(0, 2) == 0) begin
                    bph = 3'($urandom_range(3, 7));
                    if (bph == 3'd3) bph = 3'd0;
                    send(bph, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
                end
                blk = rnd128();
                send(3'd1, (before_tag == 0) ? h : rnd128(), (before_tag == 0) ? ej0 : rnd128(),
                     rnd128(), rnd128(), blk, rnd128());
                before_tag = 1;
                exp_y = gmul(exp_y ^ blk, h);
            end
            for (int p = 0; p < nP; p++) begin
                cb = rnd128(); pt = rnd128(); c = cb ^ pt;
                send(3'd2, (before_tag == 0) ? h : rnd128(), (before_tag == 0) ? ej0 : rnd128(),
                     cb, pt, rnd128(), rnd128());
                before_tag = 1;
                exp_y = gmul(exp_y ^ c, h);
                wait_ct(got);
                check($sformatf("rnd%0d_ct%0d", t, p), got, c);
            end
            sz = {64'(nA * 128), 64'(nP * 128)};
            send(3'd3, (before_tag == 0) ? h : rnd128(), (before_tag == 0) ? ej0 : rnd128(),
                 rnd128(), rnd128(), rnd128(), sz);
            exp_y = gmul(exp_y ^ sz, h);
            wait_tag(got, lat);
            check($sformatf("rnd%0d_tag", t), got, exp_y ^ ej0);
            check_int($sformatf("rnd%0d_latency", t), lat, MUL_CYC + 1);
        end
        repeat (3) @(negedge clk);
        #1;
        check_int("final_extra_ct", ct_fifo.size(), 0);
        check_int("final_extra_tag", tag_fifo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
